test_din_src: RTL and testbench
===============================

// Module: test_din_src
// PURPOSE
//   Transmit end of the din_valid/din_data stream. Feeds a test_din-style sink.
//   Accepts operand pairs plus a 3-bit opcode over a valid/ready request port.
//   Buffers them in a DEPTH-entry FIFO.
//   Emits them as single-cycle, valid-only beats with a programmable minimum idle gap.
//   The sink has no backpressure, so all flow control terminates here.
// PARAMETERS
//   DWIDTH  16  width of each operand (a, b)
//   DEPTH   4   FIFO entries; power of 2, >= 2
//   GAP     0   minimum idle cycles between consecutive din_valid beats (0..255)
// PORTS
//   clk         in   1               clock, all logic on rising edge
//   rst         in   1               synchronous reset, active-high
//   req_valid   in   1               request present
//   req_ready   out  1               FIFO can accept (not full)
//   req_op      in   3               opcode
//   req_a       in   DWIDTH          operand A
//   req_b       in   DWIDTH          operand B
//   din_valid   out  1               beat strobe to sink, one cycle per beat
//   din_data    out  2*DWIDTH+3      packed beat {op, a, b}
//   fifo_level  out  $clog2(DEPTH)+1 current FIFO occupancy
//   sent_cnt    out  16              beats emitted since reset
// BEHAVIOUR
//   Reset (rst=1 at edge): all outputs and state return to reset values.
//     - din_valid=0, din_data=0, fifo_level=0, sent_cnt=0.
//     - FIFO pointers 0, gap counter 0, FSM=IDLE.
//     - req_ready=0 while rst is high; 1 on the first cycle after release.
//   Push:
//     - Push = req_valid & req_ready.
//     - req_ready = (fifo_level != DEPTH), decoded from registered count only.
//     - When full, no push occurs even if a pop happens in the same cycle.
//   Packing: din_data = {req_op[2:0], req_a[DWIDTH-1:0], req_b[DWIDTH-1:0]}.
//     - op sits at the MSBs, b at the LSBs.
//   FSM states: IDLE, SEND, WAIT.
//     - IDLE: if fifo_level>0 -> SEND.
//     - SEND (one cycle):
//         * pop head into the din_data register and assert din_valid for the next cycle;
//         * increment sent_cnt, which wraps 0xFFFF->0;
//         * if GAP>0, load gap_cnt=GAP-1 and go to WAIT;
//         * else stay in SEND if an entry remains after this pop, otherwise go to IDLE.
//     - WAIT: decrement gap_cnt. At 0, go to SEND if fifo_level>0, else IDLE.
//   Latency: push at edge k into an empty FIFO in IDLE.
//     - FSM enters SEND at edge k+1.
//     - din_valid is high in the cycle after edge k+2.
//   Throughput: with GAP=0, one beat per cycle while the FIFO is non-empty.
//     - Otherwise one beat per GAP+1 cycles.
//   Output timing:
//     - din_valid is a registered output, high exactly one cycle per beat.
//     - din_data holds the last beat value while din_valid=0.
//   fifo_level: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
//   Pointers wrap modulo DEPTH.
//   Mid-operation reset:
//     - FIFO contents are discarded and are not emitted.
//     - A beat that would have been presented in the cycle after the reset edge is suppressed.
// TESTING
//   1. Reset release, then a single req {op=5, a=0x1234, b=0xABCD}.
//      -> one din_valid pulse 2 cycles after accept.
//      -> din_data=0x5_1234_ABCD (35b), sent_cnt=1.
//   2. GAP=0: burst of 4 back-to-back reqs.
//      -> 4 consecutive din_valid cycles, in order.
//      -> fifo_level peaks at its expected value; req_ready never drops incorrectly.
//   3. GAP=3, DEPTH=4: 6 reqs offered continuously.
//      -> req_ready low while fifo_level=4.
//      -> all 6 beats emitted, exactly 3 idle cycles between each.
//   4. FIFO full plus a pop in the same cycle with req_valid=1.
//      -> no push that cycle; push accepted on the next cycle.
//   5. Assert rst for one cycle with 3 entries queued.
//      -> din_valid=0 the following cycle, fifo_level=0, sent_cnt=0.
//      -> no stale beats afterwards.
//   6. Emit 65537 beats.
//      -> sent_cnt wraps to 1.

Source files
------------

// File: rtl/test_din_src.sv
// Source end of a din_valid/din_data stream: buffers {op, a, b} requests
// and replays them as single-cycle beats separated by a minimum idle gap.
module test_din_src #(
    parameter int DWIDTH = 16,
    parameter int DEPTH  = 4,
    parameter int GAP    = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [2:0]                req_op,
    input  logic [DWIDTH-1:0]         req_a,
    input  logic [DWIDTH-1:0]         req_b,
    output logic                      din_valid,
    output logic [2*DWIDTH+2:0]       din_data,
    output logic [$clog2(DEPTH):0]    fifo_level,
    output logic [15:0]               sent_cnt
);

    localparam int BW = 2 * DWIDTH + 3;
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    localparam logic [LW-1:0] FULL   = LW'(DEPTH);
    localparam logic [LW-1:0] ONE    = LW'(1);
    localparam logic [LW-1:0] EMPTY  = '0;
    localparam logic [7:0]    GAP_LD = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT
    } state_t;

    state_t          state;
    logic [BW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [7:0]      gap_cnt;
    logic            push;
    logic            pop;
    logic            more;

    // Ready comes only from the registered level, so a same-cycle pop
    // never opens a slot for a push when the FIFO is full.
    assign req_ready = !rst && (fifo_level != FULL);
    assign push      = req_valid && req_ready;
    assign pop       = (state == SEND);
    assign more      = (fifo_level > ONE) || push;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {req_op, req_a, req_b};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                fifo_level <= fifo_level + ONE;
            end else if (pop && !push) begin
                fifo_level <= fifo_level - ONE;
            end
        end
    end

    // Beat generator; din_valid defaults low so each beat lasts one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            gap_cnt   <= '0;
            din_valid <= 1'b0;
            din_data  <= '0;
            sent_cnt  <= '0;
        end else begin
            din_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (fifo_level != EMPTY) begin
                        state <= SEND;
                    end
                end
                SEND: begin
                    din_valid <= 1'b1;
                    din_data  <= mem[rd_ptr];
                    sent_cnt  <= sent_cnt + 16'd1;
                    if (GAP > 0) begin
                        gap_cnt <= GAP_LD;
                        state   <= WAIT;
                    end else if (more) begin
                        state <= SEND;
                    end else begin
                        state <= IDLE;
                    end
                end
                WAIT: begin
                    if (gap_cnt == 8'd0) begin
                        state <= (fifo_level != EMPTY) ? SEND : IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_test_din_src.sv
// Directed bench for test_din_src: one instance with no gap and one with
// a 3-cycle gap, checked against hand-computed beat timing and values.
module tb_test_din_src;

    localparam int DW = 16;
    localparam int BW = 2 * DW + 3;

    logic           clk = 1'b0;
    logic           rst;
    logic           v0, v3;
    logic [2:0]     op0, op3;
    logic [DW-1:0]  a0, b0, a3, b3;
    logic           rdy0, rdy3, dv0, dv3;
    logic [BW-1:0]  dd0, dd3;
    logic [2:0]     lvl0, lvl3;
    logic [15:0]    cnt0, cnt3;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    test_din_src #(.DWIDTH(DW), .DEPTH(4), .GAP(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid(v0), .req_ready(rdy0),
        .req_op(op0), .req_a(a0), .req_b(b0),
        .din_valid(dv0), .din_data(dd0),
        .fifo_level(lvl0), .sent_cnt(cnt0)
    );

    test_din_src #(.DWIDTH(DW), .DEPTH(4), .GAP(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .req_valid(v3), .req_ready(rdy3),
        .req_op(op3), .req_a(a3), .req_b(b3),
        .din_valid(dv3), .din_data(dd3),
        .fifo_level(lvl3), .sent_cnt(cnt3)
    );

    logic [BW-1:0] q0[$];
    logic [BW-1:0] q3[$];
    int            t0q[$];
    int            t3[$];
    int            nb0, tf0, tl0;
    int            max0, max3, bad0, bad3;
    logic [2:0]    lh3 [1024];

    always @(negedge clk) begin
        if (dv0) begin
            if (q0.size() < 64) begin
                q0.push_back(dd0);
                t0q.push_back(cyc);
            end
            nb0++;
            if (nb0 == 1) tf0 = cyc;
            tl0 = cyc;
        end
        if (dv3) begin
            q3.push_back(dd3);
            t3.push_back(cyc);
        end
        if (!rst) begin
            if (rdy0 != (lvl0 != 3'd4)) bad0++;
            if (rdy3 != (lvl3 != 3'd4)) bad3++;
            if (int'(lvl0) > max0) max0 = int'(lvl0);
            if (int'(lvl3) > max3) max3 = int'(lvl3);
        end
        lh3[cyc % 1024] = lvl3;
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        q0.delete();
        t0q.delete();
        q3.delete();
        t3.delete();
        nb0 = 0;
        max0 = 0;
        max3 = 0;
        bad0 = 0;
        bad3 = 0;
    endtask

    initial begin
        int k;
        int i;
        int bud;
        int n;
        int at [6];
        logic acc;
        logic [BW-1:0] e;

        rst = 1'b1;
        v0 = 1'b0; op0 = '0; a0 = '0; b0 = '0;
        v3 = 1'b0; op3 = '0; a3 = '0; b3 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_dv", dv0, 0);
        chk("rst_dd", dd0, 0);
        chk("rst_lvl", lvl0, 0);
        chk("rst_cnt", cnt0, 0);
        chk("rst_rdy", rdy0, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        clr();
        @(negedge clk);
        chk("rel_rdy0", rdy0, 1);
        chk("rel_rdy3", rdy3, 1);

        // single request
        @(posedge clk); #1;
        v0 = 1'b1; op0 = 3'd5; a0 = 16'h1234; b0 = 16'hABCD;
        @(posedge clk); #1;
        k = cyc;
        v0 = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("t1_n", q0.size(), 1);
        chk("t1_data", (q0.size() > 0) ? q0[0] : '0, 35'h5_1234_ABCD);
        chk("t1_lat", (t0q.size() > 0) ? t0q[0] - k : -1, 2);
        chk("t1_cnt", cnt0, 1);

        // back-to-back burst of 4, no gap
        clr();
        for (int j = 0; j < 4; j++) begin
            v0 = 1'b1;
            op0 = 3'(j + 1);
            a0 = 16'h0100 + 16'(j);
            b0 = 16'hF000 + 16'(j);
            @(posedge clk); #1;
            if (j == 0) k = cyc;
        end
        v0 = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("t2_n", q0.size(), 4);
        for (int j = 0; j < 4; j++) begin
            e = {3'(j + 1), 16'h0100 + 16'(j), 16'hF000 + 16'(j)};
            chk("t2_data", (q0.size() > j) ? q0[j] : '0, e);
            chk("t2_time", (t0q.size() > j) ? t0q[j] - k : -1, j + 2);
        end
        chk("t2_peak", max0, 2);
        chk("t2_rdy", bad0, 0);
        chk("t2_cnt", cnt0, 5);

        // gap of 3 with 6 requests offered continuously
        clr();
        i = 0;
        bud = 0;
        while (i < 6 && bud < 100) begin
            v3 = 1'b1;
            op3 = 3'(i + 1);
            a3 = 16'hA000 + 16'(i);
            b3 = 16'h0B00 + 16'(i);
            acc = rdy3;
            @(posedge clk); #1;
            if (acc) begin
                at[i] = cyc;
                i++;
            end
            bud++;
        end
        v3 = 1'b0;
        chk("t3_acc", i, 6);
        repeat (30) @(posedge clk);
        #1;
        k = at[0];
        chk("t3_n", q3.size(), 6);
        for (int j = 0; j < 6; j++) begin
            e = {3'(j + 1), 16'hA000 + 16'(j), 16'h0B00 + 16'(j)};
            chk("t3_data", (q3.size() > j) ? q3[j] : '0, e);
            chk("t3_time", (t3.size() > j) ? t3[j] - k : -1, 2 + 4 * j);
        end
        chk("t3_peak", max3, 4);
        chk("t3_rdy", bad3, 0);
        chk("t3_cnt", cnt3, 6);

        // full FIFO with a pop while req_valid is held
        chk("t4_acc4", at[4] - k, 4);
        chk("t4_acc5", at[5] - k, 7);
        chk("t4_lvl_full", lh3[(k + 5) % 1024], 4);
        chk("t4_lvl_pop", lh3[(k + 6) % 1024], 3);
        chk("t4_lvl_push", lh3[(k + 7) % 1024], 4);

        // reset with 3 entries queued and a beat about to be sent
        for (int j = 0; j < 4; j++) begin
            v3 = 1'b1;
            op3 = 3'd7;
            a3 = 16'hDEAD;
            b3 = 16'(j);
            @(posedge clk); #1;
            if (j == 0) k = cyc;
        end
        v3 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("t5_lvl_pre", lvl3, 3);
        chk("t5_cnt_pre", cnt3, 7);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_rdy_rst", rdy3, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        clr();
        @(negedge clk);
        chk("t5_dv", dv3, 0);
        chk("t5_lvl", lvl3, 0);
        chk("t5_cnt", cnt3, 0);
        repeat (20) @(posedge clk);
        #1;
        chk("t5_stale", q3.size(), 0);
        chk("t5_lvl_end", lvl3, 0);

        // 65537 beats, sent_cnt wraps to 1
        clr();
        v0 = 1'b1;
        op0 = 3'd3;
        a0 = 16'h5555;
        b0 = 16'hAAAA;
        n = 0;
        bud = 0;
        while (n < 65537 && bud < 70000) begin
            acc = rdy0;
            @(posedge clk); #1;
            if (acc) n++;
            bud++;
        end
        v0 = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("t6_push", n, 65537);
        chk("t6_beats", nb0, 65537);
        chk("t6_cnt", cnt0, 1);
        chk("t6_span", tl0 - tf0, 65536);
        chk("t6_lvl", lvl0, 0);
        chk("t6_rdy", bad0, 0);
        chk("t6_data", (q0.size() > 0) ? q0[0] : '0, 35'h3_5555_AAAA);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
